// File: rtl/serial_addsub.sv
// Digit-serial a+b / a-b: N=WIDTH/DIGIT RUN cycles, out_valid on the (N+1)th edge counting the accept edge;
// result held in DONE while out_ready=0, no new operands until IDLE. Optional ovf output: SERIAL_ADDSUB_OVF_EN.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_cfg_err
      $error("serial_addsub: WIDTH must be >= 2 and DIGIT must divide WIDTH");
    end
  endgenerate

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT-1:0] w_dsum;
  logic             w_cout;
  logic [WIDTH-1:0] w_sum_nxt;
  logic             w_last;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             r_ovf;
  logic             w_cmsb;
`endif

  // One DIGIT-wide ripple stage fed by the registered carry.
  always_comb begin : digit_add
    logic v_c;
    v_c    = r_carry;
    w_dsum = '0;
`ifdef SERIAL_ADDSUB_OVF_EN
    w_cmsb = r_carry;
`endif
    for (int i = 0; i < DIGIT; i++) begin
`ifdef SERIAL_ADDSUB_OVF_EN
      if (i == DIGIT - 1) w_cmsb = v_c;
`endif
      w_dsum[i] = r_a[i] ^ r_b[i] ^ v_c;
      v_c       = (r_a[i] & r_b[i]) | (v_c & (r_a[i] ^ r_b[i]));
    end
    w_cout = v_c;
  end

  // New digits enter at the MSB so the first digit lands at bit 0 after N shifts.
  generate
    if (DIGIT == WIDTH) begin : g_sum_full
      assign w_sum_nxt = w_dsum;
    end else begin : g_sum_shift
      assign w_sum_nxt = {w_dsum, r_sum[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign w_last = (r_cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_carry <= sub;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_sum   <= w_sum_nxt;
          r_carry <= w_cout;
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
`ifdef SERIAL_ADDSUB_OVF_EN
            r_ovf   <= w_cout ^ w_cmsb;
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_carry;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three instances (DIGIT 1/4/8, WIDTH 8), vector table, corner sequences, random ops vs arithmetic model.
module tb_serial_addsub;

  logic       clk;
  logic       rst_n;
  logic       iv   [3];
  logic       ir   [3];
  logic [7:0] ia   [3];
  logic [7:0] ib   [3];
  logic       isub [3];
  logic       ov   [3];
  logic       ordy [3];
  logic [7:0] osum [3];
  logic       oc   [3];
  logic       oovf [3];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      serial_addsub #(
        .WIDTH(8),
        .DIGIT((g == 0) ? 1 : ((g == 1) ? 4 : 8))
      ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (iv[g]),
        .in_ready (ir[g]),
        .a        (ia[g]),
        .b        (ib[g]),
        .sub      (isub[g]),
        .out_valid(ov[g]),
        .out_ready(ordy[g]),
        .sum      (osum[g]),
        .cout     (oc[g])
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .ovf      (oovf[g])
`endif
      );
`ifndef SERIAL_ADDSUB_OVF_EN
      assign oovf[g] = 1'b0;
`endif
    end
  endgenerate

  typedef struct {
    int         k;
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] es;
    logic       ec;
    logic       eo;
    int         el;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic s,
                                output logic [7:0] sm, output logic c, output logic o);
    int ua, ub, r, sa, sb, sr;
    ua = int'(a);
    ub = int'(b);
    r  = s ? (ua - ub) : (ua + ub);
    sm = r[7:0];
    c  = s ? (ua >= ub) : (r > 255);
    sa = int'($signed(a));
    sb = int'($signed(b));
    sr = s ? (sa - sb) : (sa + sb);
    o  = (sr > 127) || (sr < -128);
  endfunction

  // Called and returns at a negedge. Drives one op on instance k, checks result, holds hold cycles, releases.
  task automatic run_op(input string nm, input int k, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input int hold, input logic [7:0] es, input logic ec,
                        input logic eo, input int el);
    int guard;
    int lat;
    guard = 0;
    while (!ir[k] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!ir[k]) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout: in_ready stayed 0 for %0d cycles", nm, guard);
      return;
    end
    ia[k] = a; ib[k] = b; isub[k] = s; iv[k] = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) chk({nm, "_in_ready_after_accept"}, ir[k], 0);
      iv[k] = 1'b0;
      ia[k] = 8'($urandom);
      ib[k] = 8'($urandom);
      isub[k] = 1'($urandom);
    end while (!ov[k] && lat < 40);
    if (!ov[k]) begin
      checks++;
      errors++;
      $display("FAIL %s_valid_timeout: out_valid still 0 after %0d cycles", nm, lat);
      return;
    end
    chk({nm, "_lat"}, lat, el);
    chk({nm, "_sum"}, osum[k], es);
    chk({nm, "_cout"}, oc[k], ec);
`ifdef SERIAL_ADDSUB_OVF_EN
    chk({nm, "_ovf"}, oovf[k], eo);
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_bp_valid"}, ov[k], 1);
      chk({nm, "_bp_sum"}, osum[k], es);
      chk({nm, "_bp_cout"}, oc[k], ec);
      chk({nm, "_bp_in_ready"}, ir[k], 0);
    end
    ordy[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[k] = 1'b0;
    chk({nm, "_rel_valid"}, ov[k], 0);
    chk({nm, "_rel_in_ready"}, ir[k], 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    logic [7:0] es;
    logic ec, eo;
    int guard;

    tbl.push_back('{0, 8'h2D, 8'h1C, 1'b0, 8'h49, 1'b0, 1'b0, 9});
    tbl.push_back('{0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 9});
    tbl.push_back('{0, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 9});
    tbl.push_back('{0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 9});
    tbl.push_back('{0, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 9});
    tbl.push_back('{0, 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, 9});
    tbl.push_back('{1, 8'h9A, 8'h67, 1'b0, 8'h01, 1'b1, 1'b0, 3});
    tbl.push_back('{2, 8'h9A, 8'h67, 1'b0, 8'h01, 1'b1, 1'b0, 2});
    tbl.push_back('{1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 3});
    tbl.push_back('{2, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 2});

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; ia[k] = 8'h00; ib[k] = 8'h00; isub[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d_in_ready", k), ir[k], 1);
      chk($sformatf("rst%0d_out_valid", k), ov[k], 0);
      chk($sformatf("rst%0d_sum", k), osum[k], 0);
      chk($sformatf("rst%0d_cout", k), oc[k], 0);
      chk($sformatf("rst%0d_ovf", k), oovf[k], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++)
      run_op($sformatf("vec%0d", i), tbl[i].k, tbl[i].a, tbl[i].b, tbl[i].s, 0,
             tbl[i].es, tbl[i].ec, tbl[i].eo, tbl[i].el);

    // Backpressure with in_valid held high through RUN and DONE.
    ia[0] = 8'h2D; ib[0] = 8'h1C; isub[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ia[0] = 8'h33; ib[0] = 8'h11; isub[0] = 1'b1;
    guard = 0;
    while (!ov[0] && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("bp_done_valid", ov[0], 1);
    chk("bp_done_sum", osum[0], 8'h49);
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      chk("bp_hold_valid", ov[0], 1);
      chk("bp_hold_sum", osum[0], 8'h49);
      chk("bp_hold_cout", oc[0], 0);
      chk("bp_hold_in_ready", ir[0], 0);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    chk("bp_rel_valid", ov[0], 0);
    chk("bp_rel_in_ready", ir[0], 1);
    run_op("bp_second", 0, 8'h33, 8'h11, 1'b1, 0, 8'h22, 1'b1, 1'b0, 9);

    // Reset during RUN cycle 4.
    ia[0] = 8'h2D; ib[0] = 8'h1C; isub[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid_run_in_ready", ir[0], 0);
    rst_n = 1'b0;
    #1;
    chk("rst_run_in_ready", ir[0], 1);
    chk("rst_run_out_valid", ov[0], 0);
    chk("rst_run_sum", osum[0], 0);
    chk("rst_run_cout", oc[0], 0);
    chk("rst_run_ovf", oovf[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_rst", 0, 8'h01, 8'h01, 1'b0, 0, 8'h02, 1'b0, 1'b0, 9);

    for (int i = 0; i < 60; i++) begin
      int k, hold;
      logic [7:0] ra, rb;
      logic rs;
      k    = $urandom_range(0, 2);
      hold = $urandom_range(0, 2);
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rs   = 1'($urandom);
      model(ra, rb, rs, es, ec, eo);
      run_op($sformatf("rnd%0d", i), k, ra, rb, rs, hold, es, ec, eo,
             8 / ((k == 0) ? 1 : ((k == 1) ? 4 : 8)) + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
